// File: rtl/nonce_tx_queue.sv
// -----------------------------------------------------------------------------
// nonce_tx_queue
//
// Result-side stage between the SHA-256 hasher and the async_transmitter link.
// Golden nonces are buffered in a small FIFO so that back-to-back hits are not
// lost while the UART is busy. Each nonce is then sent as 4 bytes, MSB first,
// using the transmitter's start/busy handshake. Everything runs in hash_clk.
//
// Parameters
//   DEPTH_LOG2  log2 of FIFO depth in 32-bit entries (legal 1..4)
//   DROP_CNT_W  width of the saturating dropped-nonce counter
//
// Ports
//   hash_clk      in   clock, all logic on the rising edge
//   reset         in   asynchronous active-low reset
//   golden_nonce  in   [31:0] nonce from the hasher, sampled when golden_valid=1
//   golden_valid  in   one-cycle strobe marking a found nonce
//   tx_busy       in   transmitter busy flag
//   tx_data       out  [7:0] byte presented to the transmitter
//   tx_start      out  one-cycle send request to the transmitter
//   fifo_full     out  FIFO holds 2^DEPTH_LOG2 entries (registered)
//   fifo_count    out  [DEPTH_LOG2:0] current FIFO occupancy
//   drop_count    out  [DROP_CNT_W-1:0] nonces discarded on a full FIFO, saturating
// -----------------------------------------------------------------------------
module nonce_tx_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    input  logic [31:0]           golden_nonce,
    input  logic                  golden_valid,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,   // waiting for a queued nonce and an idle transmitter
        START,  // tx_start asserted for this single cycle
        ACK,    // waiting for the transmitter to raise busy
        DONE    // waiting for the transmitter to finish the byte
    } state_t;

    state_t                  state, state_next;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]     count_next;
    logic [31:0]             shift_q, shift_next;
    logic [1:0]              byte_idx, byte_idx_next;
    logic [7:0]              tx_data_next;
    logic                    pop, push, drop;

    // A pop only happens from IDLE, so a push into an empty FIFO is never
    // bypassed straight to the shift register; that gives the fixed two-cycle
    // strobe-to-tx_start latency.
    assign pop  = (state == IDLE) && (fifo_count != '0) && !tx_busy;
    // A full FIFO still accepts a nonce when the head leaves in the same cycle.
    assign push = golden_valid && (!fifo_full || pop);
    assign drop = golden_valid && fifo_full && !pop;

    assign tx_start = (state == START);

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = fifo_count + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_next = fifo_count - (DEPTH_LOG2 + 1)'(1);
            default: count_next = fifo_count;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and the occupancy
    // counter define which entries are meaningful, so clearing the data would
    // only cost reset fan-out.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr] <= golden_nonce;
        end
    end

    // NOTE: every clocked register uses non-blocking assignment so that all
    // of them update from the same pre-edge values, regardless of order.
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            drop_count <= '0;
            state      <= IDLE;
            shift_q    <= '0;
            byte_idx   <= '0;
            tx_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            fifo_count <= count_next;
            fifo_full  <= (count_next == DEPTH_CNT);
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
            state    <= state_next;
            shift_q  <= shift_next;
            byte_idx <= byte_idx_next;
            tx_data  <= tx_data_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        byte_idx_next = byte_idx;
        tx_data_next  = tx_data;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    shift_next    = mem[rd_ptr];
                    byte_idx_next = 2'd0;
                    tx_data_next  = mem[rd_ptr][31:24];
                    state_next    = START;
                end
            end
            START: begin
                state_next = ACK;
            end
            ACK: begin
                if (tx_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!tx_busy) begin
                    if (byte_idx != 2'd3) begin
                        // The next byte is loaded into tx_data on entry to START
                        // and stays there until the following START.
                        shift_next    = {shift_q[23:0], 8'h00};
                        byte_idx_next = byte_idx + 2'd1;
                        tx_data_next  = shift_q[23:16];
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_nonce_tx_queue
//
// Scoreboard bench for nonce_tx_queue. Stimulus pushes the 4 expected bytes of
// every nonce the reference model accepts into exp_q; a monitor pops and
// compares whenever the DUT pulses tx_start. A transmitter model drives busy
// one cycle after each start for a fixed or random number of cycles. A second
// instance with a 2-bit drop counter covers drop counter saturation.
// -----------------------------------------------------------------------------
module tb_nonce_tx_queue;

    localparam int DEPTH = 4;

    logic        hash_clk;
    logic        reset;
    logic [31:0] golden_nonce;
    logic        golden_valid;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_count;

    logic [31:0] golden_nonce2;
    logic        golden_valid2;
    logic [7:0]  tx_data2;
    logic        tx_start2;
    logic        fifo_full2;
    logic [2:0]  fifo_count2;
    logic [1:0]  drop_count2;

    bit tx_auto    = 1'b1;
    bit force_busy = 1'b0;
    bit model_busy = 1'b0;
    bit rand_busy  = 1'b0;

    assign tx_busy = tx_auto ? model_busy : force_busy;

    nonce_tx_queue #(.DEPTH_LOG2(2), .DROP_CNT_W(8)) u_dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .golden_nonce(golden_nonce),
        .golden_valid(golden_valid),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .drop_count  (drop_count)
    );

    nonce_tx_queue #(.DEPTH_LOG2(2), .DROP_CNT_W(2)) u_dut_sat (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .golden_nonce(golden_nonce2),
        .golden_valid(golden_valid2),
        .tx_busy     (1'b1),
        .tx_data     (tx_data2),
        .tx_start    (tx_start2),
        .fifo_full   (fifo_full2),
        .fifo_count  (fifo_count2),
        .drop_count  (drop_count2)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    int cyc = 0;
    always @(posedge hash_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Reference model output: the wire order of one accepted nonce.
    logic [7:0] exp_q [$];

    task automatic expect_nonce(input logic [31:0] n);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(n[i*8 +: 8]);
        end
    endtask

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] n);
        golden_nonce = n;
        golden_valid = 1'b1;
        step();
        golden_valid = 1'b0;
    endtask

    task automatic strobe2(input logic [31:0] n);
        golden_nonce2 = n;
        golden_valid2 = 1'b1;
        step();
        golden_valid2 = 1'b0;
    endtask

    // Transmitter model: busy rises the cycle after a start and stays high
    // for 10 cycles (or a random 1..12 cycles in the random phase).
    int busy_len   = 0;
    bit start_seen = 1'b0;

    initial begin
        forever begin
            @(negedge hash_clk);
            if (!reset) begin
                model_busy = 1'b0;
                busy_len   = 0;
                start_seen = 1'b0;
            end else begin
                if (busy_len > 0) begin
                    busy_len--;
                    if (busy_len == 0) model_busy = 1'b0;
                end else if (start_seen) begin
                    start_seen = 1'b0;
                    model_busy = 1'b1;
                    busy_len   = rand_busy ? int'($urandom_range(1, 12)) : 10;
                end
                if (tx_start && tx_auto) start_seen = 1'b1;
            end
        end
    end

    // Monitor: compares every byte offered to the transmitter.
    int frame_bytes    = 0;
    int bytes_seen     = 0;
    int frames_started = 0;
    int first_cyc      = 0;
    bit prev_start     = 1'b0;

    initial begin
        forever begin
            @(negedge hash_clk);
            if (!reset) begin
                frame_bytes = 0;
                prev_start  = 1'b0;
            end else if (tx_start) begin
                check("start_width", 32'(prev_start), 32'd0);
                bytes_seen++;
                if (frame_bytes == 0) begin
                    frames_started++;
                    first_cyc = cyc;
                end
                frame_bytes = (frame_bytes + 1) % 4;
                if (exp_q.size() == 0) begin
                    fail("unexpected_byte", $sformatf("got 0x%0h, expected no byte", tx_data));
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                prev_start = 1'b1;
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || frame_bytes != 0) && t < 3000) begin
            step();
            t++;
        end
        // Let the last byte's busy fall and the FSM settle in IDLE.
        repeat (16) step();
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_cyc;
        int b0;
        int s0;
        int t;
        int occ;
        int drops;
        int occ2;
        int drops2;
        int pushed;
        logic [31:0] n;

        reset         = 1'b1;
        golden_nonce  = '0;
        golden_valid  = 1'b0;
        golden_nonce2 = '0;
        golden_valid2 = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge hash_clk);
        #1;

        // Reset state
        check("rst_tx_start",   32'(tx_start),   32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_fifo_full",  32'(fifo_full),  32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b1;
        step();
        step();

        // Single nonce: latency and byte order
        push_cyc = cyc;
        b0 = bytes_seen;
        expect_nonce(32'hDEADBEEF);
        strobe(32'hDEADBEEF);
        check("single_count_after_push", 32'(fifo_count), 32'd1);
        drain("single");
        check("single_latency", 32'(first_cyc - push_cyc), 32'd2);
        check("single_pulses",  32'(bytes_seen - b0),      32'd4);

        // Five back-to-back nonces: one popped, four queued, none dropped
        for (int i = 1; i <= 5; i++) expect_nonce(32'(i));
        for (int i = 1; i <= 5; i++) strobe(32'(i));
        check("burst_fifo_count", 32'(fifo_count), 32'd4);
        check("burst_fifo_full",  32'(fifo_full),  32'd1);
        check("burst_drop_count", 32'(drop_count), 32'd0);
        drain("burst");
        check("burst_empty_count", 32'(fifo_count), 32'd0);
        check("burst_empty_full",  32'(fifo_full),  32'd0);

        // Reset while the second byte of a frame is being started
        expect_nonce(32'hCAFEF00D);
        strobe(32'hCAFEF00D);
        t = 0;
        while (t < 200) begin
            @(negedge hash_clk);
            #2;
            if (frame_bytes == 2 && tx_start) break;
            t++;
        end
        if (t >= 200) fail("midframe_wait", "second byte never started");
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_tx_start",   32'(tx_start),   32'd0);
        check("midrst_tx_data",    32'(tx_data),    32'd0);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_fifo_full",  32'(fifo_full),  32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        b0 = bytes_seen;
        repeat (2) @(posedge hash_clk);
        #1;
        reset = 1'b1;
        repeat (40) step();
        check("midrst_no_resume", 32'(bytes_seen - b0), 32'd0);

        // Overflow with the transmitter held busy: no pops, so the model is exact
        tx_auto    = 1'b0;
        force_busy = 1'b1;
        step();
        occ   = 0;
        drops = 0;
        for (int i = 0; i < 7; i++) begin
            if (occ < DEPTH) begin
                occ++;
                expect_nonce(32'h100 + 32'(i));
            end else begin
                drops++;
            end
            strobe(32'h100 + 32'(i));
        end
        check("ovf_drop_count", 32'(drop_count), 32'(drops));
        check("ovf_fifo_count", 32'(fifo_count), 32'(occ));
        check("ovf_fifo_full",  32'(fifo_full),  32'd1);

        // Saturating 2-bit drop counter on the second instance
        occ2   = 0;
        drops2 = 0;
        for (int i = 0; i < 9; i++) begin
            if (occ2 < DEPTH) occ2++;
            else if (drops2 < 3) drops2++;
            strobe2($urandom);
            if (i == 6) check("sat_drop_before", 32'(drop_count2), 32'(drops2));
        end
        check("sat_drop_after",  32'(drop_count2), 32'(drops2));
        check("sat_fifo_count",  32'(fifo_count2), 32'd4);
        check("sat_fifo_full",   32'(fifo_full2),  32'd1);
        check("sat_no_tx_start", 32'(tx_start2),   32'd0);
        check("sat_tx_data",     32'(tx_data2),    32'd0);

        // Push and pop in the same cycle while full
        golden_nonce = 32'hA5A55A5A;
        golden_valid = 1'b1;
        force_busy   = 1'b0;
        expect_nonce(32'hA5A55A5A);
        step();
        golden_valid = 1'b0;
        tx_auto      = 1'b1;
        check("pushpop_fifo_count", 32'(fifo_count), 32'd4);
        check("pushpop_fifo_full",  32'(fifo_full),  32'd1);
        check("pushpop_drop_count", 32'(drop_count), 32'(drops));
        drain("pushpop");

        // Random traffic through the 4-entry FIFO (pointer wrap)
        rand_busy = 1'b1;
        s0 = frames_started;
        pushed = 0;
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 5)) step();
            // Keep the FIFO from filling so every nonce is accepted.
            t = 0;
            while ((pushed - (frames_started - s0)) >= DEPTH && t < 500) begin
                step();
                t++;
            end
            if (t >= 500) fail("random_throttle", "transmission stalled");
            n = $urandom;
            expect_nonce(n);
            strobe(n);
            pushed++;
        end
        drain("random");
        check("random_frames",     32'(frames_started - s0), 32'd24);
        check("random_drop_count", 32'(drop_count),          32'(drops));
        check("random_fifo_count", 32'(fifo_count),          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nonce_tx_queue.md
Name: nonce_tx_queue

Overview:
Result-side stage between the SHA-256 hasher's golden-nonce output and the async_transmitter serial link in a miner or slave node.
- Buffers 32-bit golden nonces in a small FIFO so back-to-back hits are not lost while the UART is busy.
- Serialises each nonce into 4 bytes, MSB first, using the transmitter's start/busy handshake.
- Sits entirely in the hash_clk domain.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth in 32-bit entries (default 4 entries); legal range 1..4.
DROP_CNT_W, 8, width of the saturating dropped-nonce counter.

Ports:
hash_clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
golden_nonce  input  32  nonce from hasher; sampled only when golden_valid=1.
golden_valid  input  1  one-cycle strobe marking a found nonce.
tx_busy  input  1  async_transmitter busy flag.
tx_data  output  8  byte presented to transmitter.
tx_start  output  1  one-cycle request to transmitter.
fifo_full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
fifo_count  output  DEPTH_LOG2+1  current occupancy.
drop_count  output  DROP_CNT_W  nonces discarded due to full FIFO; saturates.

Behaviour:
- Reset (reset=0, async):
  - tx_data=0, tx_start=0, fifo_count=0, fifo_full=0, drop_count=0.
  - FSM to IDLE; write/read pointers 0.
  - An in-flight frame is abandoned and never resumed.
  - Outputs are held while reset=0; release is synchronous to hash_clk.
- FIFO write: golden_valid=1 and (not full, or a pop occurs in the same cycle) -> entry stored, pointer advances mod depth.
- Drop: golden_valid=1 while full and no same-cycle pop -> nonce discarded; drop_count += 1, saturating at all-ones.
- Simultaneous push and pop: fifo_count unchanged; ordering preserved (FIFO order, never LIFO).
- fifo_full is registered and equals (fifo_count == 2^DEPTH_LOG2).
- FSM states:
  - IDLE: if fifo_count>0 and tx_busy=0 -> pop head into 32-bit shift register, byte index=0, go to START.
  - START: tx_start=1 for exactly this cycle; tx_data = shift[31:24]; go to ACK.
  - ACK: wait for tx_busy=1 -> go to DONE. No timeout; the block waits indefinitely.
  - DONE: wait for tx_busy=0. Then:
    - index<3 -> shift left 8, index+1, go to START.
    - index=3 -> go to IDLE.
- tx_data changes only on entry to START and is held stable until the next START or reset.
- Byte order on the wire: nonce[31:24], [23:16], [15:8], [7:0].
- Latency from empty/idle (tx_busy=0): golden_valid in cycle N -> pop in N+1 -> tx_start=1 in N+2.
- Between frames the block returns to IDLE for at least one cycle, so a new frame starts no earlier than 2 cycles after the prior byte's busy falls.
- golden_valid held high for several cycles is treated as several distinct nonces; the upstream stage guarantees single-cycle strobes.
- tx_busy high in IDLE defers the pop until busy=0.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally; occupancy is tracked by a separate counter.

Test Plan:
1. Reset with reset=0 mid-frame (after byte 2 started) -> tx_start=0 immediately, fifo_count=0, drop_count=0; after release no further bytes sent.
2. Single nonce 0xDEADBEEF at cycle N with a transmitter model (busy 1 cycle after start, 10 cycles long) -> tx_start pulses at N+2 carrying DE, then AD, BE, EF; exactly 4 pulses, each 1 cycle wide.
3. Five nonces 0x00000001..0x00000005 on consecutive cycles, DEPTH_LOG2=2, transmitter busy -> first popped, remaining 4 queued; fifo_full=1; nothing dropped; all 5 nonces emitted in order (20 bytes).
4. Overflow: fill 4 entries with tx_busy forced high, then 3 more strobes -> drop_count=3, fifo_count=4; with DROP_CNT_W=2 and 5 extra strobes -> drop_count=3 (saturated).
5. Push and pop in the same cycle while full -> new nonce accepted, fifo_count stays 4, drop_count unchanged.
6. Run ≥20 nonces through a 4-entry FIFO -> pointer wrap; output byte stream matches the reference queue model exactly.
